// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler: merges load-use, divide and data-SRAM wait stalls into a
// thermometer stall bus, sequences the divider and flags SRAM wait timeouts.
module pipe_stall_ctrl #(
    parameter int STALL_W     = 6,
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stallreq_id,
    input  logic               div_start,
    input  logic               mem_req,
    input  logic               mem_ack,
    output logic [STALL_W-1:0] stall,
    output logic               div_busy,
    output logic               div_done,
    output logic               mem_timeout,
    output logic [31:0]        stall_cycles
);

    localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_CYCLES - 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    div_state_t     div_state_q;
    logic [DCW-1:0] div_cnt_q;
    mem_state_t     mem_state_q;
    logic [WCW-1:0] wait_cnt_q;
    logic [31:0]    stall_cycles_q;
    logic [31:0]    stall_cycles_d;

    logic mem_stall;
    logic div_stall;
    logic id_stall;

    assign mem_stall = mem_req & ~mem_ack;
    assign div_stall = (div_state_q == DIV_BUSY);
    assign id_stall  = stallreq_id & ~flush;

    // Deeper sources freeze a superset of stages, so each bit is a plain OR of
    // the sources that reach that depth; WB and beyond never stall.
    genvar gi;
    generate
        for (gi = 0; gi < STALL_W; gi++) begin : g_stall
            if (gi <= 2) begin : g_front
                assign stall[gi] = mem_stall | div_stall | id_stall;
            end else if (gi == 3) begin : g_ex
                assign stall[gi] = mem_stall | div_stall;
            end else if (gi == 4) begin : g_mem
                assign stall[gi] = mem_stall;
            end else begin : g_back
                assign stall[gi] = 1'b0;
            end
        end
    endgenerate

    // Divide sequencer; the count keeps running even while MEM freezes EX.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= '0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (div_start) begin
                        div_state_q <= DIV_BUSY;
                        div_cnt_q   <= DIV_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (div_cnt_q == DCW'(1)) begin
                        div_state_q <= DIV_DONE;
                        div_cnt_q   <= '0;
                    end else begin
                        div_cnt_q <= div_cnt_q - DCW'(1);
                    end
                end
                DIV_DONE: begin
                    if (!mem_stall) begin
                        div_state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    div_state_q <= DIV_IDLE;
                    div_cnt_q   <= '0;
                end
            endcase
        end
    end

    // SRAM wait tracker; a timeout drops back to IDLE so a persisting request re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_state_q <= MEM_IDLE;
            wait_cnt_q  <= '0;
        end else begin
            case (mem_state_q)
                MEM_IDLE: begin
                    if (mem_stall) begin
                        mem_state_q <= MEM_WAIT;
                        wait_cnt_q  <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall || (wait_cnt_q == WAIT_MAX)) begin
                        mem_state_q <= MEM_IDLE;
                        wait_cnt_q  <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                default: begin
                    mem_state_q <= MEM_IDLE;
                    wait_cnt_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign div_busy     = (div_state_q == DIV_BUSY);
    assign div_done     = (div_state_q == DIV_DONE);
    assign mem_timeout  = (mem_state_q == MEM_WAIT) && (wait_cnt_q == WAIT_MAX) && mem_stall;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall scheduler for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Collects three stall sources and drives the shared stall bus consumed by every stage register:
  - load-use request from ID
  - the multi-cycle divide sequence in EX (counted internally)
  - data-SRAM wait handshake in MEM
- Also sequences divider start/done, flags data-SRAM timeouts and counts stall cycles for performance monitoring.

Parameters:
- STALL_W, 6, stall bus width; bit i holds stage i (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
- DIV_CYCLES, 32, number of EX cycles a divide occupies before its result is valid (≥2).
- MEM_TIMEOUT, 255, maximum consecutive cycles in MEM wait before a timeout is flagged (≥1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  exception flush; aborts an in-progress divide.
- stallreq_id  in  1  ID load-use hazard request.
- div_start  in  1  EX holds a DIV/DIVU this cycle, operands valid.
- mem_req  in  1  MEM stage has a data-SRAM load/store this cycle.
- mem_ack  in  1  data SRAM completes the MEM access this cycle.
- stall  out  STALL_W  stall bus; 1 = Stop, 0 = NoStop.
- div_busy  out  1  divider iterating.
- div_done  out  1  divide result valid in EX.
- mem_timeout  out  1  one-cycle pulse on wait timeout.
- stall_cycles  out  32  saturating count of cycles with stall[0]=1.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. In the cycle after rst=1, all outputs are 0, both FSMs are IDLE and the counters are cleared.
- stall is combinational from current state and inputs. The deepest active source wins:
  - mem_stall → 6'b011111
  - else div_stall → 6'b001111
  - else stallreq_id & ~flush → 6'b000111
  - else 6'b000000
- stall[5] is never asserted.
- Div FSM (IDLE, BUSY, DONE), down-counter div_cnt:
  - IDLE: div_start & ~flush → BUSY, div_cnt ← DIV_CYCLES-1. div_stall=0.
  - BUSY: div_busy=1, div_stall=1, div_cnt decrements each cycle, including cycles frozen by mem_stall. At div_cnt==1 → DONE. Total BUSY cycles = DIV_CYCLES-1.
  - DONE: div_done=1, div_stall=0. If stall[3]=1 (mem_stall), stay in DONE. Otherwise → IDLE.
  - div_start outside IDLE is ignored.
  - flush in any state → IDLE next cycle, div_cnt cleared. div_busy/div_done drop with the state.
- Mem FSM (IDLE, WAIT), counter wait_cnt:
  - mem_stall = mem_req & ~mem_ack, in either state.
  - IDLE: mem_req & ~mem_ack → WAIT, wait_cnt ← 1.
  - WAIT: mem_ack → IDLE. Otherwise wait_cnt increments. When wait_cnt == MEM_TIMEOUT and still ~mem_ack, pulse mem_timeout for one cycle and return to IDLE. A persisting request re-arms the FSM.
  - mem_req=0 in WAIT → IDLE; the request was withdrawn, so no timeout.
  - mem_req & mem_ack in the same cycle → zero stall, no state change.
  - flush does not affect the Mem FSM; SRAM transactions are never aborted.
- stall_cycles: +1 every cycle stall[0]=1; holds at 32'hFFFF_FFFF.
- Simultaneous events:
  - div_start with mem_stall: the divide starts and counts while frozen.
  - stallreq_id during BUSY: masked by the deeper stall, no separate bubble.
  - flush with stallreq_id: the ID request is ignored.
- Mid-operation reset: rst overrides every state and counter in the same edge.

Test Plan:
- Reset with all inputs 0 → stall=0, div_busy=0, div_done=0, stall_cycles=0.
- stallreq_id=1 for 1 cycle → stall=6'b000111 that cycle, 0 after; stall_cycles=1.
- div_start pulse, DIV_CYCLES=32 → stall=6'b001111 for 31 cycles with div_busy=1, then 1 cycle of div_done=1 with stall=0, then IDLE.
- mem_req=1 with mem_ack at the 4th cycle → stall=6'b011111 for 3 cycles, 0 on the ack cycle; no timeout.
- mem_req=1 with mem_ack=0, MEM_TIMEOUT=4 → stall=6'b011111 each cycle; mem_timeout pulses once on the 4th WAIT cycle.
- Divide in progress, then mem_stall over the div_cnt==1 boundary → DONE held with div_done=1 while stall=6'b011111; IDLE on the cycle after mem_ack. Separately, flush during BUSY → div_busy=0 next cycle, stall=0.
